// File: rtl/mem_access_unit.sv
// Memory-stage access unit: dmem request/ack handshake, store lane steering,
// load alignment/extension and MEM/WB capture. Optional macro: MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  funct3M,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [4:0]  RdM,
  input  logic        RegWriteM,
  input  logic [31:0] PCPlus4M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        mem_fault,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RdW,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } state_t;

  localparam logic [15:0] MAX_WAIT_L = 16'(MAX_WAIT);

  state_t      state_reg, state_next;
  logic [15:0] wait_cnt_reg, wait_cnt_next;

  logic [31:0] addr_reg;
  logic        we_reg;
  logic [3:0]  be_reg;
  logic [31:0] wdata_reg;
  logic [1:0]  lane_reg;
  logic [2:0]  f3_reg;

  logic        is_load, mem_op, is_byte, is_half, misaligned, fault_now;
  logic        stall, kill;
  logic [1:0]  lane_lo;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data, rdata_wb;

  assign is_load = ~MemWriteM & (ResultSrcM == 2'b01);
  assign mem_op  = MemWriteM | is_load;

  // Store codes other than SB/SH are word-sized; loads decode size from funct3[1:0].
  assign is_byte = MemWriteM ? (funct3M == 3'b000)
                             : (funct3M == 3'b000 || funct3M == 3'b100);
  assign is_half = MemWriteM ? (funct3M == 3'b001)
                             : (funct3M == 3'b001 || funct3M == 3'b101);

  // Only the address bits meaningful for the access size select the lane.
  assign lane_lo = is_byte ? ALUResultM[1:0] :
                   is_half ? {ALUResultM[1], 1'b0} : 2'b00;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = (is_half & ALUResultM[0]) |
                      (~is_byte & ~is_half & (ALUResultM[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign fault_now = ~rst & (state_reg == IDLE) & mem_op & misaligned;

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = WriteDataM;
    if (MemWriteM) begin
      if (is_byte) begin
        be_calc    = 4'b0001 << lane_lo;
        wdata_calc = {4{WriteDataM[7:0]}};
      end else if (is_half) begin
        be_calc    = lane_lo[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{WriteDataM[15:0]}};
      end
    end
  end

  always_comb begin
    rd_byte = dmem_rdata[7:0];
    case (lane_reg)
      2'd1:    rd_byte = dmem_rdata[15:8];
      2'd2:    rd_byte = dmem_rdata[23:16];
      2'd3:    rd_byte = dmem_rdata[31:24];
      default: rd_byte = dmem_rdata[7:0];
    endcase
    rd_half = lane_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_reg)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_data = {24'd0, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_data = {16'd0, rd_half};
      default: load_data = dmem_rdata;
    endcase
  end

  // Ack wins over a timeout: the abort state is only entered without ack.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        wait_cnt_next = 16'd0;
        if (mem_op && !fault_now) state_next = BUSY;
      end
      BUSY: begin
        if (dmem_ack) begin
          state_next = IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 16'd1;
          if (wait_cnt_reg + 16'd1 == MAX_WAIT_L) state_next = ABORT;
        end
      end
      ABORT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign stall = ~rst & (((state_reg == IDLE) & mem_op & ~fault_now) |
                         ((state_reg == BUSY) & ~dmem_ack));
  assign kill     = fault_now | (state_reg == ABORT);
  assign rdata_wb = ((state_reg == BUSY) && dmem_ack && !we_reg) ? load_data : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 16'd0;
      addr_reg     <= 32'd0;
      we_reg       <= 1'b0;
      be_reg       <= 4'd0;
      wdata_reg    <= 32'd0;
      lane_reg     <= 2'd0;
      f3_reg       <= 3'd0;
      ALUResultW   <= 32'd0;
      ReadDataW    <= 32'd0;
      PCPlus4W     <= 32'd0;
      RdW          <= 5'd0;
      RegWriteW    <= 1'b0;
      ResultSrcW   <= 2'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (state_reg == IDLE && mem_op && !fault_now) begin
        addr_reg  <= {ALUResultM[31:2], 2'b00};
        we_reg    <= MemWriteM;
        be_reg    <= be_calc;
        wdata_reg <= wdata_calc;
        lane_reg  <= lane_lo;
        f3_reg    <= funct3M;
      end
      if (!stall) begin
        ALUResultW <= ALUResultM;
        ReadDataW  <= rdata_wb;
        PCPlus4W   <= PCPlus4M;
        RdW        <= RdM;
        RegWriteW  <= RegWriteM & ~kill;
        ResultSrcW <= ResultSrcM;
      end
    end
  end

  assign dmem_req   = (state_reg == BUSY);
  assign dmem_we    = we_reg;
  assign dmem_addr  = addr_reg;
  assign dmem_be    = be_reg;
  assign dmem_wdata = wdata_reg;
  assign StallM     = stall;
  assign mem_fault  = fault_now | (state_reg == ABORT);

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected MEM/WB records are queued at
// issue and compared when the unit releases the stall.
module tb_mem_access_unit;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ALUResultM = '0, WriteDataM = '0, PCPlus4M = '0;
  logic [2:0]  funct3M = '0;
  logic        MemWriteM = 1'b0, RegWriteM = 1'b0;
  logic [1:0]  ResultSrcM = '0;
  logic [4:0]  RdM = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [3:0]  dmem_be;
  logic        StallM, mem_fault, RegWriteW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
  logic [1:0]  ResultSrcW;

  mem_access_unit #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .funct3M(funct3M),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
    .RegWriteM(RegWriteM), .PCPlus4M(PCPlus4M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .StallM(StallM), .mem_fault(mem_fault),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  rs;
  } wb_t;

  wb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (!we) return 4'b1111;
    case (f3)
      3'b000:  case (a[1:0])
                 2'd0: return 4'b0001;
                 2'd1: return 4'b0010;
                 2'd2: return 4'b0100;
                 default: return 4'b1000;
               endcase
      3'b001:  return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {d[7:0], d[7:0], d[7:0], d[7:0]};
      3'b001:  return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a[1:0])
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return b[7] ? {24'hFFFFFF, b} : {24'h0, b};
      3'b100:  return {24'h0, b};
      3'b001:  return h[15] ? {16'hFFFF, h} : {16'h0, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 after the MEM/WB capture edge.
  // ack_after = N acks on the Nth request cycle; 0 never acks.
  task automatic issue(input string name, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [2:0] f3, input logic mw, input logic [1:0] rs,
                       input logic [4:0] rd, input logic rw, input logic [31:0] pc4,
                       input int ack_after, input logic [31:0] rdata);
    logic memop, ld, bsz, hsz, mis, done, first;
    int   exp_stall, exp_req, exp_fault, stall_cnt, req_cnt, fault_cnt, cycles;
    wb_t  e, g;
    ALUResultM = alu; WriteDataM = wd; funct3M = f3; MemWriteM = mw;
    ResultSrcM = rs; RdM = rd; RegWriteM = rw; PCPlus4M = pc4;
    ld    = !mw && rs == 2'b01;
    memop = mw || ld;
    bsz   = mw ? (f3 == 3'b000) : (f3 == 3'b000 || f3 == 3'b100);
    hsz   = mw ? (f3 == 3'b001) : (f3 == 3'b001 || f3 == 3'b101);
`ifdef MISALIGN_TRAP_EN
    mis = memop && ((hsz && alu[0]) || (!bsz && !hsz && alu[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
    e.alu = alu; e.pc4 = pc4; e.rd = rd; e.rs = rs; e.rw = rw; e.rdata = 32'd0;
    if (!memop) begin
      exp_stall = 0; exp_req = 0; exp_fault = 0;
    end else if (mis) begin
      exp_stall = 0; exp_req = 0; exp_fault = 1; e.rw = 1'b0;
    end else if (ack_after == 0) begin
      exp_stall = 1 + MW; exp_req = MW; exp_fault = 1; e.rw = 1'b0;
    end else begin
      exp_stall = ack_after; exp_req = ack_after; exp_fault = 0;
      if (ld) e.rdata = exp_load(f3, alu, rdata);
    end
    sb_q.push_back(e);

    stall_cnt = 0; req_cnt = 0; fault_cnt = 0; cycles = 0; done = 1'b0; first = 1'b1;
    while (!done && cycles < 40) begin
      #1;
      if (dmem_req) begin
        req_cnt++;
        if (first) begin
          first = 1'b0;
          check({name, ".addr"}, dmem_addr, {alu[31:2], 2'b00});
          check({name, ".we"}, {31'd0, dmem_we}, {31'd0, mw});
          check({name, ".be"}, {28'd0, dmem_be}, {28'd0, exp_be(mw, f3, alu)});
          if (mw) check({name, ".wdata"}, dmem_wdata, exp_wdata(f3, wd));
        end
        if (ack_after > 0 && req_cnt == ack_after) begin
          dmem_ack = 1'b1; dmem_rdata = rdata;
        end
      end
      #1;
      if (StallM) stall_cnt++;
      if (mem_fault) fault_cnt++;
      done = !StallM;
      @(posedge clk); #1;
      dmem_ack = 1'b0; dmem_rdata = 32'h5A5A_5A5A;
      cycles++;
    end
    check({name, ".done"}, {31'd0, done}, 32'd1);
    check({name, ".stall_cycles"}, stall_cnt, exp_stall);
    check({name, ".req_cycles"}, req_cnt, exp_req);
    check({name, ".fault_cycles"}, fault_cnt, exp_fault);

    g = sb_q.pop_front();
    check({name, ".ALUResultW"}, ALUResultW, g.alu);
    check({name, ".ReadDataW"}, ReadDataW, g.rdata);
    check({name, ".PCPlus4W"}, PCPlus4W, g.pc4);
    check({name, ".RdW"}, {27'd0, RdW}, {27'd0, g.rd});
    check({name, ".RegWriteW"}, {31'd0, RegWriteW}, {31'd0, g.rw});
    check({name, ".ResultSrcW"}, {30'd0, ResultSrcW}, {30'd0, g.rs});
    $display("%s addr=%h stall=%0d req=%0d fault=%0d rdw=%h", name, alu, stall_cnt,
             req_cnt, fault_cnt, ReadDataW);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst.StallM", {31'd0, StallM}, 32'd0);
    check("rst.dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rst.mem_fault", {31'd0, mem_fault}, 32'd0);
    check("rst.ALUResultW", ALUResultW, 32'd0);
    check("rst.RegWriteW", {31'd0, RegWriteW}, 32'd0);
    check("rst.dmem_be", {28'd0, dmem_be}, 32'd0);
    rst = 1'b0;

    issue("ADD0", 32'h0000_0010, 32'h0, 3'b000, 1'b0, 2'b00, 5'd1, 1'b1, 32'h104, 1, 32'h0);
    issue("SB",   32'h0000_1003, 32'hAABBCCDD, 3'b000, 1'b1, 2'b00, 5'd0, 1'b0, 32'h108, 1, 32'h0);
    issue("LB",   32'h0000_2001, 32'h0, 3'b000, 1'b0, 2'b01, 5'd5, 1'b1, 32'h10C, 3, 32'h0000_80FF);
    issue("LBU",  32'h0000_2001, 32'h0, 3'b100, 1'b0, 2'b01, 5'd6, 1'b1, 32'h110, 3, 32'h0000_80FF);
    issue("LH",   32'h0000_2002, 32'h0, 3'b001, 1'b0, 2'b01, 5'd7, 1'b1, 32'h114, 2, 32'h8001_1234);
    issue("LHU",  32'h0000_2000, 32'h0, 3'b101, 1'b0, 2'b01, 5'd8, 1'b1, 32'h118, 1, 32'h1234_F00F);
    issue("SH",   32'h0000_2002, 32'h11223344, 3'b001, 1'b1, 2'b00, 5'd0, 1'b0, 32'h11C, 2, 32'h0);
    issue("LWmis",32'h0000_3002, 32'h0, 3'b010, 1'b0, 2'b01, 5'd9, 1'b1, 32'h120, 2, 32'hCAFE_BABE);
    issue("LWto", 32'h0000_4000, 32'h0, 3'b010, 1'b0, 2'b01, 5'd10, 1'b1, 32'h124, 0, 32'h0);
    issue("ADD1", 32'h0000_0020, 32'h0, 3'b000, 1'b0, 2'b00, 5'd11, 1'b1, 32'h128, 1, 32'h0);
    issue("SW",   32'h0000_5004, 32'h1357_9BDF, 3'b010, 1'b1, 2'b00, 5'd0, 1'b0, 32'h12C, 2, 32'h0);
    issue("ADD2", 32'h0000_0030, 32'h0, 3'b000, 1'b0, 2'b00, 5'd12, 1'b1, 32'h130, 1, 32'h0);

    // Reset during the second request cycle of a load.
    ALUResultM = 32'h0000_6000; funct3M = 3'b010; MemWriteM = 1'b0; ResultSrcM = 2'b01;
    RdM = 5'd13; RegWriteM = 1'b1; PCPlus4M = 32'h134;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("rstbusy.pre_req", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstbusy.dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rstbusy.StallM", {31'd0, StallM}, 32'd0);
    check("rstbusy.mem_fault", {31'd0, mem_fault}, 32'd0);
    check("rstbusy.ALUResultW", ALUResultW, 32'd0);
    check("rstbusy.PCPlus4W", PCPlus4W, 32'd0);
    check("rstbusy.RdW", {27'd0, RdW}, 32'd0);
    check("rstbusy.dmem_addr", dmem_addr, 32'd0);
    $display("RSTBUSY req=%0d stall=%0d", dmem_req, StallM);
    ResultSrcM = 2'b00; RegWriteM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    issue("NOP",  32'h0000_0040, 32'h0, 3'b000, 1'b0, 2'b00, 5'd14, 1'b1, 32'h138, 1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
